data_sync_launcher: RTL and testbench
=====================================

# data_sync_launcher

Source-domain launcher that feeds the multi-flop bus synchronizer in the destination clock domain. It accepts words over a valid/ready handshake and drives a held-stable `unsync_bus` with a qualifying `bus_enable` level. `bus_enable` stays high long enough, and the bus stays stable long enough, for the destination synchronizer to catch the enable's rising edge and capture the bus. It then enforces a guard gap before the next launch. All logic is in the source clock domain, so the block contains no synchronizers itself.

## Interface
- BUS_WIDTH, 8, data width; must equal the downstream synchronizer's bus width.
- HOLD_CYCLES, 4, source cycles `bus_enable` stays high per word; legal range ≥1.
- GAP_CYCLES, 4, source cycles `bus_enable` stays low after each word, with the bus still held; legal range ≥1.

Ports:
- CLK  input  1  source-domain clock.
- RST  input  1  asynchronous, active-low reset.
- in_data  input  BUS_WIDTH  word to launch.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  block accepts a word this cycle; a word transfers when `in_valid & in_ready` at a CLK edge.
- unsync_bus  output  BUS_WIDTH  registered launched word, connected to the synchronizer's bus input.
- bus_enable  output  1  registered qualifier, connected to the synchronizer's enable input.
- busy  output  1  `state != IDLE`, or the pending buffer is occupied.
- tx_count  output  8  number of words launched, modulo 256.

## Operation
- States and transitions:
  - IDLE → HOLD on handshake.
  - HOLD → GAP when the counter reaches 0.
  - GAP → IDLE when the counter reaches 0 and no next word is available.
  - GAP → HOLD when the counter reaches 0 and a next word is available (pending-buffer build only).
- Down-counter width is clog2(max(HOLD_CYCLES, GAP_CYCLES)), minimum 1 bit.
- HOLD entry:
  - `unsync_bus` ← word.
  - `bus_enable` ← 1.
  - counter ← HOLD_CYCLES−1.
  - `tx_count` ← `tx_count`+1, wrapping from 255 to 0.
- GAP entry:
  - `bus_enable` ← 0.
  - counter ← GAP_CYCLES−1.
  - `unsync_bus` unchanged.
- `unsync_bus` changes only on HOLD entry. It is stable for all of HOLD and GAP and stays stable in IDLE.
- Base build: `in_ready` = (state == IDLE), combinational. It is 0 in HOLD and GAP, so input is stalled and nothing is dropped.
- Reset values:
  - state = IDLE.
  - `unsync_bus` = 0.
  - `bus_enable` = 0.
  - `tx_count` = 0.
  - `busy` = 0.
  - `in_ready` = 1, combinational from IDLE.
- Reset mid-operation: `bus_enable` falls asynchronously and the in-flight word is abandoned. Any pending word is discarded. A word whose enable had not yet been synchronized downstream is lost; this is by design.
- System constraint, met by parameter choice and checked at integration:
  - HOLD_CYCLES·T_CLK > (NUM_STAGES+1)·T_dst.
  - GAP_CYCLES·T_CLK > (NUM_STAGES+1)·T_dst.

## Timing
- Handshake at edge n gives `unsync_bus` = word and `bus_enable` = 1 after edge n, i.e. 1-cycle launch latency.
- `bus_enable` is high for exactly HOLD_CYCLES cycles, then low for at least GAP_CYCLES cycles.
- Base-build minimum launch period is HOLD_CYCLES+GAP_CYCLES+1 cycles; the extra cycle is the IDLE acceptance cycle.
- `in_valid` held high continuously: one word is accepted on every IDLE cycle.

## Configuration
- `DATA_LAUNCH_PENDING_EN` defined: adds a one-entry pending buffer.
  - `in_ready` = !pend_valid, in any state.
  - A handshake in HOLD or GAP fills the buffer.
  - A handshake in IDLE launches directly.
  - On the last GAP cycle the next word is the pending word if present, else the same-cycle handshake word (bypass). Either goes straight to HOLD.
  - Sustained period is HOLD_CYCLES+GAP_CYCLES.
  - Invariant: pend_valid is never 1 in IDLE.
- `DATA_LAUNCH_PENDING_EN` undefined: no buffer; base behaviour only.

## Test plan
- Reset then a single word, in_data=0xA5 at edge 0 → after edge 0 `bus_enable`=1 for 4 cycles, `unsync_bus`=0xA5 through GAP and IDLE, `tx_count`=1, `busy`=0 after 8 cycles.
- Back-to-back, `in_valid` held with words 0x11, 0x22, 0x33 → base build: `bus_enable` rising edges 9 cycles apart, `in_ready` low during HOLD and GAP. Pending build: rising edges 8 cycles apart, `bus_enable` low for exactly 4 cycles between words.
- Pending build, 0x5A offered mid-HOLD and 0x6B offered immediately after → 0x5A buffered and `in_ready`=0. 0x6B stalls until 0x5A enters HOLD, then is accepted.
- RST asserted during the 2nd HOLD cycle of 0xC3 → all outputs take their reset values immediately. After release, 0x3C launches normally and `tx_count`=1.
- 256 words launched → `tx_count` wraps to 0. Full system with the downstream synchronizer at a 3:1 clock ratio → every word captured once, in order, with no duplicates.

Source files
------------

// File: rtl/data_sync_launcher.sv
// data_sync_launcher: source-domain launcher for a multi-flop bus synchronizer.
// Holds a word on unsync_bus with bus_enable high for HOLD_CYCLES, then low
// for GAP_CYCLES (bus still held), so the destination side can catch the
// enable edge and sample a stable bus.
// Optional feature macro: DATA_LAUNCH_PENDING_EN adds a one-entry pending
// buffer so a new word can be accepted while the current one is in flight.
module data_sync_launcher #(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 busy,
  output logic [7:0]           tx_count
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC <= 1) ? 1 : $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [BUS_WIDTH-1:0] r_bus;
  logic [BUS_WIDTH-1:0] w_bus_next;
  logic                 r_en;
  logic                 w_en_next;
  logic [7:0]           r_tx;
  logic [7:0]           w_tx_next;
  logic                 w_accept;
  logic                 w_launch;
  logic [BUS_WIDTH-1:0] w_launch_data;

`ifdef DATA_LAUNCH_PENDING_EN
  logic                 r_pend_valid;
  logic                 w_pend_valid_next;
  logic [BUS_WIDTH-1:0] r_pend_data;
  logic [BUS_WIDTH-1:0] w_pend_data_next;

  // The buffer is the only thing that can refuse a word.
  assign in_ready = !r_pend_valid;
  assign busy     = (r_state != IDLE) || r_pend_valid;
`else
  // Without a buffer, words are only taken while nothing is in flight.
  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
`endif

  assign w_accept   = in_valid & in_ready;
  assign unsync_bus = r_bus;
  assign bus_enable = r_en;
  assign tx_count   = r_tx;

  // Next-state logic: sequence HOLD/GAP timing and decide when a word launches.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_bus_next    = r_bus;
    w_en_next     = r_en;
    w_tx_next     = r_tx;
    w_launch      = 1'b0;
    w_launch_data = in_data;
`ifdef DATA_LAUNCH_PENDING_EN
    w_pend_valid_next = r_pend_valid;
    w_pend_data_next  = r_pend_data;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) w_launch = 1'b1;
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_next = GAP;
          w_en_next    = 1'b0;
          w_cnt_next   = GAP_LOAD;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
`ifdef DATA_LAUNCH_PENDING_EN
        if (w_accept) begin
          w_pend_valid_next = 1'b1;
          w_pend_data_next  = in_data;
        end
`endif
      end
      GAP: begin
        if (r_cnt == '0) begin
`ifdef DATA_LAUNCH_PENDING_EN
          // Buffered word has priority; otherwise a same-cycle word bypasses.
          if (r_pend_valid) begin
            w_launch          = 1'b1;
            w_launch_data     = r_pend_data;
            w_pend_valid_next = 1'b0;
          end else if (w_accept) begin
            w_launch = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
`else
          w_state_next = IDLE;
`endif
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
`ifdef DATA_LAUNCH_PENDING_EN
          if (w_accept) begin
            w_pend_valid_next = 1'b1;
            w_pend_data_next  = in_data;
          end
`endif
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (w_launch) begin
      w_state_next = HOLD;
      w_bus_next   = w_launch_data;
      w_en_next    = 1'b1;
      w_cnt_next   = HOLD_LOAD;
      w_tx_next    = r_tx + 8'd1;
    end
  end

  // State registers; reset drops bus_enable immediately and abandons any word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bus   <= '0;
      r_en    <= 1'b0;
      r_tx    <= 8'd0;
`ifdef DATA_LAUNCH_PENDING_EN
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bus   <= w_bus_next;
      r_en    <= w_en_next;
      r_tx    <= w_tx_next;
`ifdef DATA_LAUNCH_PENDING_EN
      r_pend_valid <= w_pend_valid_next;
      r_pend_data  <= w_pend_data_next;
`endif
    end
  end

endmodule

// File: tb/tb_data_sync_launcher.sv
// Testbench for data_sync_launcher: directed scenarios plus randomized traffic,
// checked every cycle against a timeline model (launch time + word queue).
module tb_data_sync_launcher;

  localparam int H = 4;
  localparam int G = 4;
`ifdef DATA_LAUNCH_PENDING_EN
  localparam bit PEND = 1'b1;
  localparam int PER  = H + G;
`else
  localparam bit PEND = 1'b0;
  localparam int PER  = H + G + 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] unsync_bus;
  logic       bus_enable;
  logic       busy;
  logic [7:0] tx_count;

  data_sync_launcher #(.BUS_WIDTH(8), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .busy(busy), .tx_count(tx_count)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time of the last launch, the held word, the counter and
  // the queue of words accepted but not yet launched.
  longint     t = 0;
  bit         m_act = 1'b0;
  longint     m_L = 0;
  logic [7:0] m_bus = 8'h00;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_q[$];
  int         m_launches = 0;
  bit         g_acc = 1'b0;
  bit         prev_en = 1'b0;
  longint     rises[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, t);
    end
  endtask

  function automatic bit m_idle();
    return !m_act || (t > m_L + H + G);
  endfunction

  function automatic bit m_ready();
    return PEND ? (m_q.size() == 0) : m_idle();
  endfunction

  function automatic bit m_en();
    return m_act && (t > m_L) && (t <= m_L + H);
  endfunction

  task automatic m_launch(input logic [7:0] d);
    m_act = 1'b1;
    m_L   = t;
    m_bus = d;
    m_tx  = m_tx + 8'd1;
    m_launches++;
  endtask

  task automatic m_reset();
    m_act = 1'b0;
    m_bus = 8'h00;
    m_tx  = 8'h00;
    m_q.delete();
  endtask

  task automatic model_edge();
    bit acc;
    logic [7:0] d;
    g_acc = 1'b0;
    if (!RST) return;
    acc   = in_valid && m_ready();
    d     = in_data;
    g_acc = acc;
    if (m_idle()) begin
      if (acc) m_launch(d);
    end else if (t == m_L + H + G) begin
      if (m_q.size() > 0) m_launch(m_q.pop_front());
      else if (acc) m_launch(d);
    end else if (acc) begin
      m_q.push_back(d);
    end
  endtask

  // One clock cycle: compare all outputs at the falling edge, then advance the model.
  task automatic cyc();
    @(negedge CLK);
    check_val("in_ready",   32'(in_ready),   32'(m_ready()));
    check_val("bus_enable", 32'(bus_enable), 32'(m_en()));
    check_val("unsync_bus", 32'(unsync_bus), 32'(m_bus));
    check_val("tx_count",   32'(tx_count),   32'(m_tx));
    check_val("busy",       32'(busy),       32'(!m_idle() || m_q.size() != 0));
    if (bus_enable && !prev_en) rises.push_back(t);
    prev_en = bus_enable;
    @(posedge CLK);
    model_edge();
    t++;
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(m_idle() && m_q.size() == 0) && k < 50) begin
      cyc();
      k++;
    end
    check_val("wait_idle_bound", 32'(k < 50), 32'd1);
  endtask

  task automatic send_one(input logic [7:0] d);
    int k = 0;
    in_data  = d;
    in_valid = 1'b1;
    cyc();
    while (!g_acc && k < 50) begin
      cyc();
      k++;
    end
    check_val("send_bound", 32'(g_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  logic [7:0] words[3];
  int idx;
  int kk;

  initial begin
    // Reset values
    repeat (2) cyc();
    RST = 1'b1;

    // Single word, full HOLD/GAP/IDLE sequence
    send_one(8'hA5);
    repeat (10) cyc();
    check_val("a5_bus_held", 32'(unsync_bus), 32'hA5);

    // Back-to-back with valid held: launch spacing
    wait_idle();
    rises.delete();
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    idx = 0; kk = 0;
    in_valid = 1'b1;
    in_data  = words[0];
    while (idx < 3 && kk < 100) begin
      cyc();
      kk++;
      if (g_acc) begin
        idx++;
        if (idx < 3) in_data = words[idx];
      end
    end
    in_valid = 1'b0;
    check_val("b2b_accepted", 32'(idx), 32'd3);
    repeat (12) cyc();
    check_val("b2b_rises", 32'(rises.size()), 32'd3);
    if (rises.size() >= 3) begin
      check_val("b2b_period1", 32'(rises[1] - rises[0]), 32'(PER));
      check_val("b2b_period2", 32'(rises[2] - rises[1]), 32'(PER));
    end

`ifdef DATA_LAUNCH_PENDING_EN
    // Word offered mid-HOLD is buffered; the next one stalls until it launches
    wait_idle();
    send_one(8'h01);
    cyc();
    send_one(8'h5A);
    check_val("pend_ready_low", 32'(in_ready), 32'd0);
    send_one(8'h6B);
    repeat (20) cyc();
`endif

    // Reset during the second HOLD cycle
    wait_idle();
    in_data  = 8'hC3;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    #2;
    RST = 1'b0;
    #1;
    check_val("rst_enable", 32'(bus_enable), 32'd0);
    check_val("rst_bus",    32'(unsync_bus), 32'd0);
    check_val("rst_tx",     32'(tx_count),   32'd0);
    check_val("rst_busy",   32'(busy),       32'd0);
    check_val("rst_ready",  32'(in_ready),   32'd1);
    m_reset();
    repeat (2) cyc();
    RST = 1'b1;
    send_one(8'h3C);
    repeat (10) cyc();
    check_val("post_rst_tx", 32'(tx_count), 32'd1);

    // Randomized traffic, long enough for tx_count to wrap
    kk = 0;
    while (m_launches < 300 && kk < 6000) begin
      in_valid = ($urandom_range(0, 7) != 0);
      in_data  = 8'($urandom);
      cyc();
      kk++;
    end
    in_valid = 1'b0;
    check_val("random_bound", 32'(m_launches >= 300), 32'd1);
    repeat (12) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
